// File: rtl/reservation_price_pkg.sv
// Shared types for the reservation-price block: fixed-point format, FSM states, FIFO entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reservation_price_pkg;

  // Fractional bits of every Q.32 quantity on the datapath.
  localparam int FRAC_BITS = 32;

  // Field widths of a buffered sample; these track the default top-level parameters.
  localparam int ENT_DATA_W = 32;
  localparam int ENT_FP_W   = ENT_DATA_W + FRAC_BITS;
  localparam int ENT_ID_W   = 2;

  // One state per multiply step, plus pop and result stages.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SQ   = 3'd1,
    ST_GAM  = 3'd2,
    ST_TIME = 3'd3,
    ST_INV  = 3'd4,
    ST_OUT  = 3'd5
  } state_t;

  // Everything about a sample that is captured on arrival; gamma and T-t are taken at pop.
  typedef struct packed {
    logic [ENT_ID_W-1:0]   stock_id;
    logic [ENT_DATA_W-1:0] price;
    logic [ENT_FP_W-1:0]   sigma;
    logic [ENT_DATA_W-1:0] q;
    logic                  buffer_full;
  } fifo_entry_t;

  // Integer magnitude of a two's-complement position (most negative value maps to 2^(W-1)).
  function automatic logic [ENT_DATA_W-1:0] abs_q(input logic [ENT_DATA_W-1:0] q);
    return q[ENT_DATA_W-1] ? (~q + 1'b1) : q;
  endfunction

endpackage

// File: rtl/reservation_price_if.sv
// Sample/result bundle between the volatility stage, the reservation-price block and its consumer.
// Latency: n/a (wiring only).
// Backpressure: none; samples are strobes and the block drops what it cannot buffer.
interface reservation_price_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_STOCKS   = 4,
  parameter int FP_WORD_SIZE = 64
);
  localparam int ID_W = $clog2(NUM_STOCKS);

  logic [ID_W-1:0]         i_stock_id;
  logic                    i_data_valid;
  logic [FP_WORD_SIZE-1:0] i_volatility;
  logic [DATA_WIDTH-1:0]   i_curr_price;
  logic                    i_buffer_full;
  logic [DATA_WIDTH-1:0]   i_inventory;
  logic [FP_WORD_SIZE-1:0] i_gamma;
  logic [FP_WORD_SIZE-1:0] i_time_left;
  logic [FP_WORD_SIZE-1:0] o_reservation_price;
  logic [ID_W-1:0]         o_stock_id;
  logic                    o_data_valid;
  logic                    o_overflow;

  // Upstream / test side: drives samples, observes results.
  modport master (
    output i_stock_id, i_data_valid, i_volatility, i_curr_price,
           i_buffer_full, i_inventory, i_gamma, i_time_left,
    input  o_reservation_price, o_stock_id, o_data_valid, o_overflow
  );

  // Block side.
  modport slave (
    input  i_stock_id, i_data_valid, i_volatility, i_curr_price,
           i_buffer_full, i_inventory, i_gamma, i_time_left,
    output o_reservation_price, o_stock_id, o_data_valid, o_overflow
  );
endinterface

// File: rtl/reservation_fifo.sv
// Small synchronous FIFO with show-ahead read data and count-based full/empty.
// Latency: write visible at rd_data the cycle after wr_en; same-cycle write+read allowed even when full.
// Backpressure: none internally; the caller must not write when full without a read, nor read when empty.
module reservation_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/reservation_price.sv
// Avellaneda-Stoikov reservation price r = price*2^32 - q*gamma*sigma^2*(T-t), Q.32, one shared multiplier.
// Latency: 6 cycles from sample strobe to result strobe when idle; one result every 6 cycles.
// Backpressure: none; a sample arriving with a full buffer and no pop is dropped and o_overflow sticks.
// Build option: define RESERVATION_SATURATE_EN to saturate products and clamp r instead of wrapping.
module reservation_price
  import reservation_price_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_STOCKS   = 4,
  parameter int FP_WORD_SIZE = 64,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  reservation_price_if.slave   bus
);
  localparam int ID_W   = $clog2(NUM_STOCKS);
  localparam int FP     = FP_WORD_SIZE;
  localparam int PROD_W = 2 * FP_WORD_SIZE;
  localparam int ENT_W  = $bits(fifo_entry_t);

  state_t state;
  state_t state_nxt;

  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              push;
  fifo_entry_t       wr_ent;
  fifo_entry_t       rd_ent;
  logic [ENT_W-1:0]  wr_bits;
  logic [ENT_W-1:0]  rd_bits;

  // Operands latched at pop.
  logic [DATA_WIDTH-1:0] price_r;
  logic [DATA_WIDTH-1:0] q_mag;
  logic                  q_neg;
  logic                  full_r;
  logic [ID_W-1:0]       id_r;
  logic [FP-1:0]         gamma_r;
  logic [FP-1:0]         time_r;
  logic [FP-1:0]         acc;

  // Shared multiplier.
  logic [FP-1:0]         mul_b;
  logic [PROD_W-1:0]     prod;
  logic [FP-1:0]         step;
  logic                  unused_prod_bits;

  // Result path.
  logic [FP-1:0]         price_fp;
  logic [FP-1:0]         risk;
  logic [FP-1:0]         r_next;
  logic [FP-1:0]         r_q;
  logic [ID_W-1:0]       id_q;
  logic                  vld_q;
  logic                  ovf_q;

  // A write is accepted whenever there is room, or when a pop frees a slot in the same cycle.
  assign push = bus.i_data_valid && (!fifo_full || pop);

  // Pack the arriving sample into a buffer entry.
  always_comb begin
    wr_ent             = '0;
    wr_ent.stock_id    = bus.i_stock_id;
    wr_ent.price       = bus.i_curr_price;
    wr_ent.sigma       = bus.i_volatility;
    wr_ent.q           = bus.i_inventory;
    wr_ent.buffer_full = bus.i_buffer_full;
  end

  assign wr_bits = wr_ent;
  assign rd_ent  = rd_bits;

  reservation_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_reset_n),
    .wr_en   (push),
    .wr_data (wr_bits),
    .rd_en   (pop),
    .rd_data (rd_bits),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Fixed six-step sequence; IDLE waits for a buffered sample and pops it.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_SQ;
        end
      end
      ST_SQ:   state_nxt = ST_GAM;
      ST_GAM:  state_nxt = ST_TIME;
      ST_TIME: state_nxt = ST_INV;
      ST_INV:  state_nxt = ST_OUT;
      ST_OUT:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Second multiplier operand per step; acc holds sigma at SQ so that step squares it.
  // The position is an integer, so it is shifted into Q.32 to share the same [95:32] slice.
  always_comb begin
    mul_b = '0;
    case (state)
      ST_SQ:   mul_b = acc;
      ST_GAM:  mul_b = gamma_r;
      ST_TIME: mul_b = time_r;
      ST_INV:  mul_b = {q_mag, {FRAC_BITS{1'b0}}};
      default: mul_b = '0;
    endcase
  end

  assign prod = {{FP{1'b0}}, acc} * {{FP{1'b0}}, mul_b};

`ifdef RESERVATION_SATURATE_EN
  assign step = (|prod[PROD_W-1:FRAC_BITS+FP]) ? '1 : prod[FRAC_BITS +: FP];
`else
  assign step = prod[FRAC_BITS +: FP];
`endif

  assign unused_prod_bits = ^{prod[PROD_W-1:FRAC_BITS+FP], prod[FRAC_BITS-1:0]};

  // Apply the sign of q at the subtraction; an unfilled history window forces the risk term to zero.
  always_comb begin
    price_fp = {price_r, {FRAC_BITS{1'b0}}};
    risk     = full_r ? step : '0;
`ifdef RESERVATION_SATURATE_EN
    begin : sat_sub
      logic [FP:0] sum_ext;
      sum_ext = {1'b0, price_fp} + {1'b0, risk};
      if (q_neg)                r_next = sum_ext[FP] ? '1 : sum_ext[FP-1:0];
      else if (risk > price_fp) r_next = '0;
      else                      r_next = price_fp - risk;
    end
`else
    r_next = q_neg ? (price_fp + risk) : (price_fp - risk);
`endif
  end

  // Datapath: latch operands on pop, accumulate each product, publish the result out of INV.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      price_r <= '0;
      q_mag   <= '0;
      q_neg   <= 1'b0;
      full_r  <= 1'b0;
      id_r    <= '0;
      gamma_r <= '0;
      time_r  <= '0;
      acc     <= '0;
      r_q     <= '0;
      id_q    <= '0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            price_r <= rd_ent.price;
            q_mag   <= abs_q(rd_ent.q);
            q_neg   <= rd_ent.q[DATA_WIDTH-1];
            full_r  <= rd_ent.buffer_full;
            id_r    <= rd_ent.stock_id;
            acc     <= rd_ent.sigma;
            gamma_r <= bus.i_gamma;
            time_r  <= bus.i_time_left;
          end
        end
        ST_SQ, ST_GAM, ST_TIME: acc <= step;
        ST_INV: begin
          r_q   <= r_next;
          id_q  <= id_r;
          vld_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sticky drop indicator: sample offered while the buffer is full and nothing leaves.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                                       ovf_q <= 1'b0;
    else if (bus.i_data_valid && fifo_full && !pop)       ovf_q <= 1'b1;
  end

  assign bus.o_reservation_price = r_q;
  assign bus.o_stock_id          = id_q;
  assign bus.o_data_valid        = vld_q;
  assign bus.o_overflow          = ovf_q;

endmodule

// File: tb/tb_reservation_price.sv
// Randomized plus directed bench for reservation_price against an arithmetic reference model.
// Latency: checks the 6-cycle sample-to-result timing and 6-cycle throughput under bursts.
// Backpressure: exercises buffer overflow, sticky o_overflow and reset mid-computation.
module tb_reservation_price;

  localparam logic [63:0] Q1   = 64'h1_0000_0000;
  localparam logic [63:0] HALF = 64'h0_8000_0000;
  localparam logic [63:0] TWO  = 64'h2_0000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   nvec  = 0;
  int   nerr  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reservation_price_if #(.DATA_WIDTH(32), .NUM_STOCKS(4), .FP_WORD_SIZE(64)) bus ();

  reservation_price #(
    .DATA_WIDTH   (32),
    .NUM_STOCKS   (4),
    .FP_WORD_SIZE (64),
    .FIFO_DEPTH   (4)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  typedef struct {
    logic [1:0]  id;
    logic [63:0] r;
    int          cyc;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One truncating Q.32 multiply of non-negative operands.
  function automatic logic [63:0] fp_mul(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
`ifdef RESERVATION_SATURATE_EN
    if (p[127:96] != 0) return '1;
`endif
    return p[95:32];
  endfunction

  // r = price - q*gamma*sigma^2*(T-t), evaluated in wide signed arithmetic.
  function automatic logic [63:0] model_r(input logic [31:0] price, input logic [63:0] sigma,
                                          input logic [63:0] gamma, input logic [63:0] tl,
                                          input logic [31:0] q, input logic full);
    logic [63:0]         v;
    logic signed [131:0] rk;
    logic signed [131:0] ex;
    logic signed [131:0] lim;
    if (!full) return {price, 32'd0};
    v   = fp_mul(fp_mul(fp_mul(sigma, sigma), gamma), tl);
    rk  = $signed({68'd0, v}) * $signed({{100{q[31]}}, q});
    lim = $signed({68'd0, {64{1'b1}}});
`ifdef RESERVATION_SATURATE_EN
    if (rk > lim)  rk = lim;
    if (rk < -lim) rk = -lim;
`endif
    ex = $signed({68'd0, price, 32'd0}) - rk;
`ifdef RESERVATION_SATURATE_EN
    if (ex < 0)   ex = 0;
    if (ex > lim) ex = lim;
`endif
    return ex[63:0];
  endfunction

  // Present one sample for one cycle; optionally expect its result lat cycles later.
  task automatic send(input logic [1:0] id, input logic [31:0] price, input logic [63:0] sigma,
                      input logic [63:0] gamma, input logic [63:0] tl, input logic [31:0] q,
                      input logic full, input logic [63:0] exp_r, input bit expect_out, input int lat);
    exp_t e;
    bus.i_stock_id    = id;
    bus.i_curr_price  = price;
    bus.i_volatility  = sigma;
    bus.i_gamma       = gamma;
    bus.i_time_left   = tl;
    bus.i_inventory   = q;
    bus.i_buffer_full = full;
    bus.i_data_valid  = 1'b1;
    if (expect_out) begin
      e.id  = id;
      e.r   = exp_r;
      e.cyc = cyc + lat;
      expq.push_back(e);
    end
    @(posedge clk);
    #1 bus.i_data_valid = 1'b0;
  endtask

  // Wait (bounded) for every expected result to appear.
  task automatic drain();
    for (int i = 0; i < 200 && expq.size() != 0; i++) @(posedge clk);
    chk("drain", 64'(expq.size()), 64'd0);
    expq.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_vld"}, 64'(bus.o_data_valid), 64'd0);
    chk({tag, "_ovf"}, 64'(bus.o_overflow), 64'd0);
    chk({tag, "_r"},   bus.o_reservation_price, 64'd0);
    chk({tag, "_id"},  64'(bus.o_stock_id), 64'd0);
  endtask

  // Result monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.o_data_valid !== 1'b0) begin
      if (expq.size() == 0) begin
        chk("spurious_vld", 64'(bus.o_data_valid), 64'd0);
      end else begin
        mon_e = expq.pop_front();
        chk("r", bus.o_reservation_price, mon_e.r);
        chk("id", 64'(bus.o_stock_id), 64'(mon_e.id));
        chk("latency", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rid;
    logic [31:0] rprice;
    logic [63:0] rsig;
    logic [63:0] rgam;
    logic [63:0] rtl;
    logic [31:0] rq;
    logic        rfull;

    bus.i_stock_id    = '0;
    bus.i_data_valid  = 1'b0;
    bus.i_volatility  = '0;
    bus.i_curr_price  = '0;
    bus.i_buffer_full = 1'b0;
    bus.i_inventory   = '0;
    bus.i_gamma       = '0;
    bus.i_time_left   = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed points with hand-derived results.
    send(2'd1, 32'd100, Q1, HALF, Q1, 32'd2, 1'b1, 64'h63_0000_0000, 1'b1, 6);
    drain();
    send(2'd2, 32'd100, Q1, HALF, Q1, 32'hFFFF_FFFC, 1'b1, 64'h66_0000_0000, 1'b1, 6);
    drain();
    send(2'd3, 32'd100, Q1, HALF, Q1, 32'd0, 1'b1, 64'h64_0000_0000, 1'b1, 6);
    drain();
    send(2'd0, 32'd100, {$urandom, $urandom}, HALF, Q1, $urandom, 1'b0, 64'h64_0000_0000, 1'b1, 6);
    drain();
`ifdef RESERVATION_SATURATE_EN
    send(2'd1, 32'd1, TWO, Q1, Q1, 32'd10, 1'b1, 64'h0, 1'b1, 6);
`else
    send(2'd1, 32'd1, TWO, Q1, Q1, 32'd10, 1'b1, 64'hFFFF_FFD9_0000_0000, 1'b1, 6);
`endif
    drain();

    // Six back-to-back samples: five buffered in order at one per 6 cycles, sixth dropped.
    for (int k = 0; k < 6; k++) begin
      chk("ovf_before_drop", 64'(bus.o_overflow), 64'd0);
      send(2'(k), 32'(10 + 2 * k), Q1, Q1, Q1, 32'(k), 1'b1,
           {32'(10 + k), 32'd0}, (k < 5), 6 + 5 * k);
    end
    chk("ovf_set", 64'(bus.o_overflow), 64'd1);
    drain();
    chk("ovf_sticky", 64'(bus.o_overflow), 64'd1);

    // Reset while the sample sits in TIME: nothing may come out, everything returns to zero.
    send(2'd3, 32'd55, Q1, Q1, Q1, 32'd5, 1'b1, 64'h0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    chk_zero_outputs("mid_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk_zero_outputs("post_reset");
    send(2'd2, 32'd100, Q1, HALF, Q1, 32'd2, 1'b1, 64'h63_0000_0000, 1'b1, 6);
    drain();

    // Randomized samples, spaced so each starts from an idle pipeline.
    for (int n = 0; n < 40; n++) begin
      rid    = 2'($urandom_range(0, 3));
      rprice = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 5000));
      rsig   = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom}
                                           : {29'd0, 3'($urandom_range(0, 3)), 32'($urandom)};
      rgam   = {30'd0, 2'($urandom_range(0, 1)), 32'($urandom)};
      rtl    = {30'd0, 2'($urandom_range(0, 2)), 32'($urandom)};
      rq     = ($urandom_range(0, 7) == 0) ? $urandom : (32'($urandom_range(0, 2000)) - 32'd1000);
      rfull  = ($urandom_range(0, 9) != 0);
      send(rid, rprice, rsig, rgam, rtl, rq, rfull,
           model_r(rprice, rsig, rgam, rtl, rq, rfull), 1'b1, 6);
      repeat ($urandom_range(5, 8)) @(posedge clk);
      #1;
    end
    drain();
    chk("ovf_final", 64'(bus.o_overflow), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
